// File: rtl/weight_fifo_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : weight_fifo_loader_pkg
// Description : Shared constants and FSM encoding for the weight loader and
//               the downstream FIFO / systolic array.
//               c_DATA_W / c_DEPTH / c_ADDR_W / c_RD_LAT : default parameters
//               c_LANES / c_LANE_W : row lane layout (16 x 8b)
//               state_t            : loader FSM encoding (2-bit, IDLE = 0)
// Revision    : 1.0  initial release
// ============================================================================
package weight_fifo_loader_pkg;

    localparam int c_DATA_W = 128;
    localparam int c_DEPTH  = 4;
    localparam int c_ADDR_W = 8;
    localparam int c_RD_LAT = 1;
    localparam int c_LANES  = 16;
    localparam int c_LANE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : weight_fifo_loader_pkg
`default_nettype wire

// File: rtl/weight_fifo_loader_rd_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : weight_fifo_loader_rd_valid_pipe
// Description : RD_LAT-stage 1-bit shift register that delays the buffer read
//               strobe so it lines up with the returned read data.
//               clk     in  : clock
//               reset_n in  : asynchronous active-low reset
//               flush   in  : synchronous clear of every stage
//               din     in  : read strobe
//               dout    out : read data valid
// Revision    : 1.0  initial release
// ============================================================================
module weight_fifo_loader_rd_valid_pipe
    import weight_fifo_loader_pkg::*;
#(
    parameter int RD_LAT = c_RD_LAT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [RD_LAT-1:0] r_pipe;

    generate
        if (RD_LAT == 1) begin : g_single
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pipe <= '0;
                end else if (flush) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= din;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pipe <= '0;
                end else if (flush) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[RD_LAT-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = r_pipe[RD_LAT-1];

endmodule : weight_fifo_loader_rd_valid_pipe
`default_nettype wire

// File: rtl/weight_fifo_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_fifo_loader
// Description : Reads DEPTH consecutive rows from the on-chip buffer on a
//               start pulse and pushes them, in address order, into the
//               shift FIFO in front of the systolic array. In IDLE a drain
//               request pushes a zero row.
//               start/base_addr  in  : load request and first row address
//               clear            in  : synchronous abort back to IDLE
//               shift_req        in  : drain request (IDLE only)
//               busy/done        out : load in progress / load-complete pulse
//               mem_rd_*         i/o : buffer read port (RD_LAT latency)
//               fifo_en/fifo_din out : FIFO shift enable and write data
// Revision    : 1.0  initial release
// ============================================================================
module weight_fifo_loader
    import weight_fifo_loader_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH,
    parameter int ADDR_W = c_ADDR_W,
    parameter int RD_LAT = c_RD_LAT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              clear,
    input  logic              shift_req,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              fifo_en,
    output logic [DATA_W-1:0] fifo_din
);

    localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [c_CNT_W-1:0]  r_rd_cnt;    // read strobes already issued
    logic [c_CNT_W-1:0]  r_push_cnt;  // rows already pushed into the FIFO
    logic                w_rd_valid;
    logic [ADDR_W-1:0]   w_rd_addr_nxt;

    // Address arithmetic wraps naturally at 2^ADDR_W.
    assign w_rd_addr_nxt = r_base + ADDR_W'(r_rd_cnt);

    weight_fifo_loader_rd_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_valid_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (clear),
        .din     (mem_rd_en),
        .dout    (w_rd_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_rd_cnt    <= '0;
            r_push_cnt  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            fifo_en     <= 1'b0;
            fifo_din    <= '0;
        end else if (clear) begin
            // Abort: in-flight data is dropped by flushing the valid pipe.
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_rd_cnt    <= '0;
            r_push_cnt  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            fifo_en     <= 1'b0;
            fifo_din    <= '0;
        end else begin
            done     <= 1'b0;
            fifo_en  <= 1'b0;
            fifo_din <= '0;

            // Returned rows are registered straight into the FIFO port.
            if (w_rd_valid) begin
                fifo_en    <= 1'b1;
                fifo_din   <= mem_rd_data;
                r_push_cnt <= r_push_cnt + c_CNT_ONE;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // First strobe is issued on the accepting edge, so
                        // READ is entered with one read already counted.
                        r_base      <= base_addr;
                        r_rd_cnt    <= c_CNT_ONE;
                        r_push_cnt  <= '0;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= base_addr;
                        busy        <= 1'b1;
                        r_state     <= ST_READ;
                    end else if (shift_req) begin
                        fifo_en  <= 1'b1;
                        fifo_din <= '0;
                    end
                end
                ST_READ: begin
                    if (r_rd_cnt == c_DEPTH_CNT) begin
                        mem_rd_en   <= 1'b0;
                        mem_rd_addr <= '0;
                        r_state     <= ST_WAIT;
                    end else begin
                        mem_rd_addr <= w_rd_addr_nxt;
                        r_rd_cnt    <= r_rd_cnt + c_CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (r_push_cnt == c_DEPTH_CNT) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : weight_fifo_loader
`default_nettype wire

// File: tb/tb_weight_fifo_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_fifo_loader
// Description : Self-checking bench for weight_fifo_loader: directed cases
//               plus randomized start/clear/shift_req traffic checked against
//               a cycle-schedule model of a load.
// Revision    : 1.0  initial release
// ============================================================================
module tb_weight_fifo_loader;

    localparam int DW = 128;
    localparam int AW = 8;
    localparam logic [DW-1:0] ROW_A = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    localparam logic [DW-1:0] ROW_B = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    localparam logic [DW-1:0] ROW_C = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
    localparam logic [DW-1:0] ROW_D = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          clear;
    logic          shift_req;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          fifo_en;
    logic [DW-1:0] fifo_din;

    logic [DW-1:0] mem [256];
    logic [3:0][DW-1:0] fq = '0;   // attached 4-deep shift FIFO, fq[3] is its output

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    weight_fifo_loader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .clear       (clear),
        .shift_req   (shift_req),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .fifo_en     (fifo_en),
        .fifo_din    (fifo_din)
    );

    // Buffer with one cycle of read latency, and the downstream shift FIFO.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (fifo_en)   fq <= {fq[2:0], fifo_din};
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a load accepted at edge s drives, in the cycle
    // following edge s+d: read strobe for d=0..3 (addr base+d), push of
    // row base+d-2 for d=2..5, busy for d=0..5, done at d=6. The loader is
    // back in IDLE only from edge s+8 on.
    // ------------------------------------------------------------------
    int            k = 0;
    int            m_start = 0;
    int            d;
    bit            m_load = 0;
    bit            m_active;
    bit            m_drain;
    logic [AW-1:0] m_base = '0;
    logic [AW-1:0] m_a;
    logic          e_busy = 0, e_done = 0, e_rd = 0, e_fen = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_din = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_load = 0;
            e_busy = 0; e_done = 0; e_rd = 0; e_fen = 0; e_addr = '0; e_din = '0;
        end else begin
            k++;
            m_drain = 0;
            if (clear) begin
                m_load = 0;
            end else begin
                m_active = m_load && (k - m_start <= 7);
                if (!m_active && start) begin
                    m_load  = 1;
                    m_start = k;
                    m_base  = base_addr;
                end else if (!m_active && shift_req) begin
                    m_drain = 1;
                end
            end
            e_busy = 0; e_done = 0; e_rd = 0; e_fen = 0; e_addr = '0; e_din = '0;
            if (m_load) begin
                d = k - m_start;
                if (d <= 3) begin
                    e_rd   = 1;
                    e_addr = m_base + 8'(d);
                end
                if (d >= 2 && d <= 5) begin
                    e_fen = 1;
                    m_a   = m_base + 8'(d - 2);
                    e_din = mem[m_a];
                end
                e_busy = (d <= 5);
                e_done = (d == 6);
            end
            if (m_drain) begin
                e_fen = 1;
                e_din = '0;
            end
        end
    end

    // Per-cycle comparison plus per-load protocol checks.
    int   pc = 0;
    logic prev_done = 0;

    always @(negedge clk) begin
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("mem_rd_en", mem_rd_en, e_rd);
        chk("fifo_en", fifo_en, e_fen);
        if (e_rd)  chk("mem_rd_addr", mem_rd_addr, e_addr);
        if (e_fen) chk("fifo_din", fifo_din, e_din);
        if (fifo_en && busy) pc++;
        if (done) begin
            chk("pushes_per_load", pc, 4);
            chk("done_width", prev_done, 0);
            pc = 0;
        end else if (!busy) begin
            pc = 0;
        end
        prev_done = done;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic kick(input logic [AW-1:0] b);
        base_addr = b;
        start     = 1'b1;
        step(1);            // cycle 1 of the load
        start     = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; clear = 1'b0; shift_req = 1'b0; base_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[8'h10] = ROW_A; mem[8'h11] = ROW_B; mem[8'h12] = ROW_C; mem[8'h13] = ROW_D;
        step(3);
        reset_n = 1'b1;
        step(1);

        // Reset in the middle of a load: outputs drop immediately.
        kick(8'h40);
        step(2);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        chk("rst_fifo_en", fifo_en, 0);
        chk("rst_fifo_din", fifo_din, 0);
        chk("rst_done", done, 0);
        step(2);
        reset_n = 1'b1;
        step(1);

        // Directed load at 0x10 with hand-computed timing.
        kick(8'h10);
        chk("t2_addr_c1", mem_rd_addr, 8'h10);
        chk("t2_rd_en_c1", mem_rd_en, 1);
        step(2);
        chk("t2_din_c3", fifo_din, ROW_A);
        step(1);
        chk("t2_din_c4", fifo_din, ROW_B);
        step(3);
        chk("t2_done_c7", done, 1);
        chk("t2_fifo_out", fq[3], ROW_A);
        step(2);

        // Address wrap.
        kick(8'hFE);
        step(2);
        chk("t3_addr_c3", mem_rd_addr, 8'h00);
        step(1);
        chk("t3_addr_c4", mem_rd_addr, 8'h01);
        step(6);

        // Second start during an active load is ignored.
        kick(8'h33);
        step(2);
        start = 1'b1; base_addr = 8'h80;
        step(1);
        start = 1'b0;
        step(8);

        // Clear mid-load, then a fresh load fills the FIFO again.
        kick(8'h55);
        step(3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t5_busy_c5", busy, 0);
        chk("t5_fifo_en_c5", fifo_en, 0);
        step(4);
        kick(8'h10);
        step(6);
        chk("t5_done_again", done, 1);
        chk("t5_fifo_out", fq[3], ROW_A);
        step(2);

        // Drain, then drain together with start.
        shift_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t6_drain_en", fifo_en, 1);
            chk("t6_drain_din", fifo_din, 0);
        end
        shift_req = 1'b0;
        step(1);
        chk("t6_drain_stop", fifo_en, 0);
        shift_req = 1'b1;
        kick(8'h20);
        shift_req = 1'b0;
        chk("t6_start_wins_rd", mem_rd_en, 1);
        chk("t6_start_wins_en", fifo_en, 0);
        step(9);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            shift_req = ($urandom_range(0, 3) == 0);
            base_addr = 8'($urandom);
            step(1);
        end
        start = 1'b0; clear = 1'b0; shift_req = 1'b0;
        step(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_weight_fifo_loader
`default_nettype wire
